// File: rtl/tff_toggle_sched_pkg.sv
// tff_sched_pkg: shared FSM state type and one-hot round-robin pick helper
package tff_sched_pkg;
  localparam int MAXREQ = 32;
  typedef enum logic [1:0] {IDLE, GRANT, PAUSE} state_t;
  function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] elig, input int n, input int ptr);
    logic [MAXREQ-1:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < MAXREQ; i++) begin
      idx = (ptr + i) % n;
      if (i < n && r == '0 && elig[idx]) r[idx] = 1'b1;
    end
    return r;
  endfunction
endpackage

// File: rtl/tff_toggle_sched_if.sv
// tff_toggle_sched_if: requester-side and bank-side signal bundle of the toggle scheduler
interface tff_toggle_sched_if #(parameter int NREQ = 4, parameter int WIDTH = 8, parameter int CNT_W = 16);
  logic [NREQ-1:0] req;
  logic [NREQ*WIDTH-1:0] mask;
  logic hold;
  logic clr;
  logic [NREQ-1:0] gnt;
  logic busy;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] grant_cnt;
  modport master (output req, mask, hold, clr, input gnt, busy, q, grant_cnt);
  modport slave (input req, mask, hold, clr, output gnt, busy, q, grant_cnt);
endinterface

// File: rtl/tff_bank.sv
// tff_bank: WIDTH T flip-flops with async active-low reset and sync clear that beats toggling
module tff_bank #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);
  // Toggle where t is set; a clear drops any toggle arriving on the same edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else q <= clr ? '0 : q ^ t;
endmodule

// File: rtl/tff_toggle_sched.sv
// tff_toggle_sched: round-robin sharing of one T flip-flop bank; define TFF_SCHED_FIXED_PRIO_EN for fixed lowest-index priority
module tff_toggle_sched
  import tff_sched_pkg::*;
#(parameter int NREQ = 4, parameter int WIDTH = 8, parameter int CNT_W = 16) (
  input logic clk,
  input logic rst,
  tff_toggle_sched_if.slave bus
);
  state_t state;
  logic [NREQ-1:0] gnt, elig, pick;
  logic [WIDTH-1:0] t_vec, pick_mask;
  logic [CNT_W-1:0] cnt;
  logic go;
  assign elig = (state != PAUSE && !bus.hold) ? bus.req & ~gnt : '0;
  assign go = |elig;
`ifdef TFF_SCHED_FIXED_PRIO_EN
  assign pick = NREQ'(rr_pick(MAXREQ'(elig), NREQ, 0));
`else
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0] ptr, nxt_ptr;
  assign pick = NREQ'(rr_pick(MAXREQ'(elig), NREQ, int'(ptr)));
  // Next search start is just past the winner; unchanged when nobody wins
  always_comb begin
    nxt_ptr = ptr;
    for (int i = 0; i < NREQ; i++) if (pick[i]) nxt_ptr = (i == NREQ - 1) ? '0 : PW'(i + 1);
  end
  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '0;
    else ptr <= nxt_ptr;
`endif
  // Winner's mask becomes the bank's toggle vector
  always_comb begin
    pick_mask = '0;
    for (int i = 0; i < NREQ; i++) pick_mask |= pick[i] ? bus.mask[i*WIDTH +: WIDTH] : '0;
  end
  // Grant FSM with registered grant, toggle vector and saturating grant count
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      gnt <= '0;
      t_vec <= '0;
      cnt <= '0;
    end else begin
      state <= bus.hold ? PAUSE : go ? GRANT : IDLE;
      gnt <= pick;
      t_vec <= pick_mask;
      cnt <= (go && cnt != '1) ? cnt + 1'b1 : cnt;
    end
  tff_bank #(.WIDTH(WIDTH)) u_bank (.clk(clk), .rst(rst), .clr(bus.clr), .t(t_vec), .q(bus.q));
  assign bus.gnt = gnt;
  assign bus.busy = (state == GRANT);
  assign bus.grant_cnt = cnt;
endmodule

// File: tb/tb_tff_toggle_sched.sv
// tb_tff_toggle_sched: table-driven and scoreboard checks of the toggle scheduler
module tb_tff_toggle_sched;
  typedef struct {
    logic [3:0]  req;
    logic [31:0] mask;
    logic        hold;
    logic        clr;
    logic [3:0]  eg;
    logic [7:0]  eq;
    logic        eb;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic sb_en = 1'b1;
  logic [3:0] sb_q[$];
  logic [3:0] sb_e;
  vec_t tbl[$];
  tff_toggle_sched_if #(.NREQ(4), .WIDTH(8), .CNT_W(16)) bus();
  tff_toggle_sched #(.NREQ(4), .WIDTH(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic vec_t v(logic [3:0] req, logic [31:0] mask, logic hold, logic clr, logic [3:0] eg, logic [7:0] eq, logic eb);
    vec_t x;
    x.req = req; x.mask = mask; x.hold = hold; x.clr = clr; x.eg = eg; x.eq = eq; x.eb = eb;
    return x;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.req = tbl[i].req;
      bus.mask = tbl[i].mask;
      bus.hold = tbl[i].hold;
      bus.clr = tbl[i].clr;
      if (tbl[i].eg != 0) sb_q.push_back(tbl[i].eg);
      step();
      check($sformatf("row%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].eg));
      check($sformatf("row%0d_q", i), 32'(bus.q), 32'(tbl[i].eq));
      check($sformatf("row%0d_busy", i), 32'(bus.busy), 32'(tbl[i].eb));
    end
  endtask
  always @(negedge clk)
    if (sb_en && bus.gnt != 0) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: gnt=%b with no grant expected", bus.gnt);
      end else begin
        sb_e = sb_q.pop_front();
        if (bus.gnt !== sb_e) begin
          errors++;
          $display("FAIL sb_order: gnt=%b expected %b", bus.gnt, sb_e);
        end
      end
    end
  initial begin
    tbl.push_back(v(4'b0001, 32'h0000_00A5, 0, 0, 4'b0001, 8'h00, 1));
    tbl.push_back(v(4'b0000, 32'h0000_00A5, 0, 0, 4'b0000, 8'hA5, 0));
    tbl.push_back(v(4'b0001, 32'h0000_00A5, 0, 0, 4'b0001, 8'hA5, 1));
    tbl.push_back(v(4'b0000, 32'h0000_00A5, 0, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(v(4'b1111, 32'h0804_0201, 0, 0, 4'b0001, 8'h00, 1));
    tbl.push_back(v(4'b1111, 32'h0804_0201, 0, 0, 4'b0010, 8'h01, 1));
    tbl.push_back(v(4'b1111, 32'h0804_0201, 0, 0, 4'b0100, 8'h03, 1));
    tbl.push_back(v(4'b1111, 32'h0804_0201, 0, 0, 4'b1000, 8'h07, 1));
    tbl.push_back(v(4'b1111, 32'h0804_0201, 0, 0, 4'b0001, 8'h0F, 1));
    tbl.push_back(v(4'b0000, 32'h0804_0201, 0, 0, 4'b0000, 8'h0E, 0));
    tbl.push_back(v(4'b0000, 32'h0804_0201, 0, 0, 4'b0000, 8'h0E, 0));
    tbl.push_back(v(4'b0001, 32'h0000_0FFF, 0, 0, 4'b0001, 8'h00, 1));
    tbl.push_back(v(4'b0010, 32'h0000_0FFF, 0, 0, 4'b0010, 8'hFF, 1));
    tbl.push_back(v(4'b0000, 32'h0000_0FFF, 0, 1, 4'b0000, 8'h00, 0));
    tbl.push_back(v(4'b0000, 32'h0000_0FFF, 0, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(v(4'b0100, 32'h0804_0201, 0, 0, 4'b0100, 8'h00, 1));
    tbl.push_back(v(4'b1001, 32'h0804_0201, 1, 0, 4'b0000, 8'h04, 0));
    tbl.push_back(v(4'b1001, 32'h0804_0201, 1, 0, 4'b0000, 8'h04, 0));
    tbl.push_back(v(4'b1001, 32'h0804_0201, 0, 0, 4'b0000, 8'h04, 0));
    tbl.push_back(v(4'b1001, 32'h0804_0201, 0, 0, 4'b1000, 8'h04, 1));
    tbl.push_back(v(4'b0001, 32'h0804_0201, 0, 0, 4'b0001, 8'h0C, 1));
    tbl.push_back(v(4'b0000, 32'h0804_0201, 0, 0, 4'b0000, 8'h0D, 0));
    tbl.push_back(v(4'b0010, 32'h0804_0001, 0, 0, 4'b0010, 8'h0D, 1));
    tbl.push_back(v(4'b0000, 32'h0804_0001, 0, 0, 4'b0000, 8'h0D, 0));
    bus.req = '0;
    bus.mask = '0;
    bus.hold = 1'b0;
    bus.clr = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_q", 32'(bus.q), 0);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_cnt", 32'(bus.grant_cnt), 0);
    check("rst_busy", 32'(bus.busy), 0);
    #1 rst = 1'b1;
    step();
    step();
    check("idle_q", 32'(bus.q), 0);
    check("idle_gnt", 32'(bus.gnt), 0);
    check("idle_cnt", 32'(bus.grant_cnt), 0);
    check("idle_busy", 32'(bus.busy), 0);
    run_rows(0, 3);
    check("single_cnt", 32'(bus.grant_cnt), 2);
    do_reset();
    run_rows(4, 10);
    check("rr_cnt", 32'(bus.grant_cnt), 5);
    do_reset();
    run_rows(11, 23);
    check("clr_hold_cnt", 32'(bus.grant_cnt), 6);
    do_reset();
    sb_en = 1'b0;
    bus.req = 4'b0011;
    bus.mask = 32'h0000_0201;
    for (int i = 0; i < 65541; i++) step();
    check("sat_gnt", 32'(bus.gnt), 32'h1);
    check("sat_cnt", 32'(bus.grant_cnt), 32'hFFFF);
    check("sat_busy", 32'(bus.busy), 1);
    rst = 1'b0;
    #1;
    check("midrst_gnt", 32'(bus.gnt), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_cnt", 32'(bus.grant_cnt), 0);
    check("midrst_q", 32'(bus.q), 0);
    #1 rst = 1'b1;
    bus.req = 4'b1111;
    sb_en = 1'b1;
    sb_q.push_back(4'b0001);
    step();
    check("post_rst_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    step();
    step();
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tff_toggle_sched.md
Name: tff_toggle_sched

Overview:
- Round-robin scheduler that shares one bank of T flip-flops between NREQ requesters.
- Each requester presents a WIDTH-bit toggle mask. The scheduler grants one requester per cycle and drives the bank's T inputs with the winner's mask.
- The bank state q is exported. The block sits between control agents and the toggle-register datapath.

Parameters:
NREQ, 4, number of requesters (>=2)
WIDTH, 8, number of T flip-flops in the bank
CNT_W, 16, width of the saturating grant counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset (0 = reset)
req  in  NREQ  per-requester request, level
mask  in  NREQ*WIDTH  toggle masks; requester i owns bits [i*WIDTH +: WIDTH]
hold  in  1  pause new grants
clr  in  1  synchronous clear of bank state
gnt  out  NREQ  one-hot grant, registered
busy  out  1  high while state is GRANT
q  out  WIDTH  T flip-flop bank state
grant_cnt  out  CNT_W  saturating count of grants issued

Behaviour:
- Reset (rst=0, async): all outputs are 0. State = IDLE; rr pointer = 0; latched t_vec = 0.
- FSM states: IDLE, GRANT, PAUSE.
  - IDLE: if hold=1 -> PAUSE; else if an eligible req exists -> GRANT; else stay.
  - GRANT: gnt is one-hot for exactly one cycle. Next state: hold=1 -> PAUSE; another eligible req -> GRANT (back-to-back); none -> IDLE.
  - PAUSE: gnt=0, no arbitration. hold=0 -> IDLE.
- Eligibility: req[i]=1, and i is not the requester granted in the current cycle. No back-to-back grant to the same requester; the requester drops req during its gnt cycle.
- Arbitration:
  - Search starts at the rr pointer, ascending, with wrap.
  - On a grant to w: pointer <= (w+1) mod NREQ.
  - Pointer is unchanged when nothing is granted.
- Timing:
  - req high before edge k -> gnt[w]=1 in the cycle after edge k, and t_vec <= mask[w] at edge k.
  - At edge k+1: q <= q ^ t_vec. q therefore changes 2 edges after req is sampled.
  - t_vec is 0 whenever no grant is issued.
- Handshake: mask[i] must be stable while req[i]=1. Only the value captured at the grant edge matters.
- Zero mask: the grant is still issued and counted; q is unchanged.
- clr:
  - At the edge where clr=1: q <= 0, and this beats a simultaneous t_vec toggle (that toggle is lost).
  - Arbitration and grants are unaffected by clr.
- hold asserted while a t_vec is already latched: that toggle is still applied on the next edge. Only new grants stop.
- grant_cnt: +1 per gnt cycle; saturates at all-ones and does not wrap.
- rst=0 mid-operation: everything clears immediately, any latched toggle is dropped, and the pointer returns to 0.
- busy = (state == GRANT).

Optional Feature:
TFF_SCHED_FIXED_PRIO_EN
- Defined: fixed priority; lowest index wins. The rr pointer is removed and the no-back-to-back rule still applies.
- Undefined: round-robin as above.

Decomposition:
- Package tff_sched_pkg:
  - FSM state enum (IDLE/GRANT/PAUSE)
  - helper function: round-robin pick, returning a one-hot result
- Sub-module tff_bank: WIDTH T flip-flops with async active-low rst, sync clr (priority over toggle), and a t vector input.

Test Plan:
1. Reset check: rst=0 -> q=0, gnt=0, grant_cnt=0, busy=0. Release rst, req=0 -> outputs stay 0.
2. Single requester: req=0001, mask0=8'hA5 -> gnt=0001 one cycle later, q=8'hA5 the edge after. Repeat -> q=8'h00, grant_cnt=2.
3. Round-robin: req=1111 held (each requester drops and re-raises after its grant), masks 01/02/04/08 -> grant order 0,1,2,3,0. q accumulates to 8'h0F after the first four grants.
4. Simultaneous clr and toggle: q=8'hFF, grant with mask 8'h0F, clr=1 at the apply edge -> q=8'h00.
5. hold: hold=1 in the cycle after gnt=0100 -> the pending toggle is still applied, no further gnt while hold=1; release -> the next grant goes to 3.
6. Saturation and mid-op reset: preload grant_cnt near all-ones -> it holds at 16'hFFFF. Pulse rst=0 during GRANT -> gnt=0 immediately, and after release the first grant goes to requester 0.
